// File: rtl/vocoder_pkg.sv
// vocoder_pkg: shared state encoding and a constant-width helper for the
// vocoder decimating delay-line controller.
package vocoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vocoder_ctrl_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   push, wdata    write strobe and data (ignored when full)
//   pop            read strobe (ignored when empty)
//   full, empty    occupancy flags
//   rdata          head word; forced to 0 when empty
module sample_fifo
  import vocoder_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem_q[rd_q];

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/vocoder_ctrl.sv
// vocoder_ctrl: sequencer for the decimating delay line. Samples shift through
// a SIZE-deep line; in RUN every ratio-th tail word is queued for downstream.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_ratio, cfg_load   decimation ratio (0 means 1) and its load strobe
//   in_valid/in_ready/in_data     sample input handshake
//   out_valid/out_ready/out_data  output FIFO handshake (FWFT)
//   busy                  controller not idle
//
// state    | meaning
// ST_IDLE  | waiting for the first cfg_load
// ST_FILL  | priming the delay line with SIZE samples
// ST_RUN   | streaming; tail pushed when phase is 0
// ST_FLUSH | input stalled until the output FIFO drains
module vocoder_ctrl
  import vocoder_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int SIZE      = 3,
  parameter int RATIO_W   = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               cfg_load,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int FW = clog2(SIZE);
  localparam logic [RATIO_W-1:0] RATIO_ONE = RATIO_W'(1);

  state_t             state_q;
  logic [RATIO_W-1:0] ratio_q;
  logic [RATIO_W-1:0] phase_q;
  logic [FW-1:0]      fill_q;
  logic [WIDTH-1:0]   line_q [SIZE];

  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic [RATIO_W-1:0] ratio_new;

  assign in_ready  = (state_q == ST_FILL) | ((state_q == ST_RUN) & ~fifo_full);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = ~fifo_empty;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push      = (state_q == ST_RUN) & accept & (phase_q == '0);
  assign ratio_new = (cfg_ratio == '0) ? RATIO_ONE : cfg_ratio;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ratio_q <= RATIO_ONE;
      phase_q <= '0;
      fill_q  <= '0;
      for (int i = 0; i < SIZE; i++) line_q[i] <= '0;
    end else begin
      if (cfg_load) ratio_q <= ratio_new;
      case (state_q)
        ST_IDLE: begin
          if (cfg_load) state_q <= ST_FILL;
        end
        ST_FILL: begin
          // a reload restarts priming and drops the sample taken this cycle
          if (cfg_load) begin
            fill_q <= '0;
            for (int i = 0; i < SIZE; i++) line_q[i] <= '0;
          end else if (accept) begin
            for (int i = SIZE-1; i > 0; i--) line_q[i] <= line_q[i-1];
            line_q[0] <= in_data;
            if (fill_q == FW'(SIZE-1)) begin
              fill_q  <= '0;
              state_q <= ST_RUN;
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            for (int i = SIZE-1; i > 0; i--) line_q[i] <= line_q[i-1];
            line_q[0] <= in_data;
            phase_q   <= (phase_q == ratio_q - RATIO_ONE) ? '0 : phase_q + 1'b1;
          end
          if (cfg_load) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            phase_q <= '0;
            for (int i = 0; i < SIZE; i++) line_q[i] <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (line_q[SIZE-1]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (out_data)
  );

endmodule
